// File: rtl/bcd_count_controller.sv
// bcd_count_controller: button edge detection, command arbitration,
// STOP/RUN tick gating and a DIGITS-wide BCD up/down counter.
//
// state | meaning
// STOP  | Tick strobes are ignored; buttons still operate the counter
// RUN   | Tick strobes count up by one
module bcd_count_controller #(
    parameter int DIGITS = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  BtnUp,
    input  logic                  BtnDown,
    input  logic                  BtnClear,
    input  logic                  BtnStart,
    input  logic                  Tick,
    output logic [4*DIGITS-1:0]   Digits,
    output logic                  Running,
    output logic                  Carry,
    output logic                  Borrow
);

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } stateT;

    stateT               state;
    logic [3:0]          btnLevels;
    logic [3:0]          syncS1;
    logic [3:0]          syncS2;
    logic [3:0]          btnEdges;
    logic                upEdge;
    logic                downEdge;
    logic                clearEdge;
    logic                startEdge;
    logic [4*DIGITS-1:0] incValue;
    logic [4*DIGITS-1:0] decValue;
    logic                incWrap;
    logic                decWrap;

    assign btnLevels = {BtnStart, BtnClear, BtnDown, BtnUp};
    assign btnEdges  = syncS1 & ~syncS2;
    assign upEdge    = btnEdges[0];
    assign downEdge  = btnEdges[1];
    assign clearEdge = btnEdges[2];
    assign startEdge = btnEdges[3];

    // Two-flop pipeline per button; the edge is S1 high while S2 is still low.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            syncS1 <= 4'b0000;
            syncS2 <= 4'b0000;
        end else begin
            syncS1 <= btnLevels;
            syncS2 <= syncS1;
        end
    end

    // Ripple increment: digits at 9 roll to 0 and pass the carry upward.
    always_comb begin
        incValue = Digits;
        incWrap  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (incWrap) begin
                if (Digits[4*i +: 4] >= 4'd9) begin
                    incValue[4*i +: 4] = 4'd0;
                end else begin
                    incValue[4*i +: 4] = Digits[4*i +: 4] + 4'd1;
                    incWrap            = 1'b0;
                end
            end
        end
    end

    // Ripple decrement: digits at 0 roll to 9 and pass the borrow upward.
    always_comb begin
        decValue = Digits;
        decWrap  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (decWrap) begin
                if (Digits[4*i +: 4] == 4'd0) begin
                    decValue[4*i +: 4] = 4'd9;
                end else begin
                    decValue[4*i +: 4] = Digits[4*i +: 4] - 4'd1;
                    decWrap            = 1'b0;
                end
            end
        end
    end

    // STOP/RUN state, arbitrated counter update and registered wrap pulses.
    // The tick gate looks at the state before any Start toggle this cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= STOP;
            Running <= 1'b0;
            Digits  <= '0;
            Carry   <= 1'b0;
            Borrow  <= 1'b0;
        end else begin
            Carry  <= 1'b0;
            Borrow <= 1'b0;
            if (clearEdge) begin
                Digits <= '0;
            end else if (downEdge) begin
                Digits <= decValue;
                Borrow <= decWrap;
            end else if (upEdge || (Tick && (state == RUN))) begin
                Digits <= incValue;
                Carry  <= incWrap;
            end

            case (state)
                STOP: begin
                    if (startEdge) begin
                        state   <= RUN;
                        Running <= 1'b1;
                    end
                end
                RUN: begin
                    if (startEdge) begin
                        state   <= STOP;
                        Running <= 1'b0;
                    end
                end
                default: begin
                    state   <= STOP;
                    Running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_count_controller.sv
// Directed bench for bcd_count_controller (DIGITS = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_count_controller;

    logic        Clk;
    logic        Reset;
    logic        BtnUp;
    logic        BtnDown;
    logic        BtnClear;
    logic        BtnStart;
    logic        Tick;
    logic [15:0] Digits;
    logic        Running;
    logic        Carry;
    logic        Borrow;

    int nCompared   = 0;
    int nMismatched = 0;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int CLEAR = 2;
    localparam int START = 3;

    bcd_count_controller #(.DIGITS(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .BtnUp    (BtnUp),
        .BtnDown  (BtnDown),
        .BtnClear (BtnClear),
        .BtnStart (BtnStart),
        .Tick     (Tick),
        .Digits   (Digits),
        .Running  (Running),
        .Carry    (Carry),
        .Borrow   (Borrow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic setBtn(input int which, input logic val);
        case (which)
            UP:      BtnUp    = val;
            DOWN:    BtnDown  = val;
            CLEAR:   BtnClear = val;
            default: BtnStart = val;
        endcase
    endtask

    // Two clocks high, two clocks low; the command has executed on return.
    task automatic press(input int which);
        setBtn(which, 1'b1);
        cyc(2);
        setBtn(which, 1'b0);
        cyc(2);
    endtask

    task automatic tickPulses(input int n);
        repeat (n) begin
            Tick = 1'b1;
            cyc(1);
            Tick = 1'b0;
            cyc(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0; BtnUp = 1'b0; BtnDown = 1'b0; BtnClear = 1'b0;
        BtnStart = 1'b0; Tick = 1'b0;

        // Reset and idle
        cyc(2);
        checkVal("reset_outputs", {Digits, Running, Carry, Borrow}, {16'h0000, 3'b000});
        Reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            checkVal("idle_outputs", {Digits, Running, Carry, Borrow}, {16'h0000, 3'b000});
        end

        // Single held press: two-clock latency, one count while held
        BtnUp = 1'b1;
        cyc(1);
        checkVal("up_latency_k", Digits, 16'h0000);
        cyc(1);
        checkVal("up_latency_k1", Digits, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            checkVal("up_held", Digits, 16'h0001);
        end
        BtnUp = 1'b0;
        cyc(2);
        for (int i = 0; i < 9; i++) press(UP);
        checkVal("up_ten", Digits, 16'h0010);
        checkVal("no_carry_ripple", {Carry, Borrow}, 2'b00);

        // Down to zero, then borrow wrap
        for (int i = 0; i < 10; i++) press(DOWN);
        checkVal("down_to_zero", Digits, 16'h0000);
        BtnDown = 1'b1;
        cyc(2);
        checkVal("borrow_wrap", {Digits, Carry, Borrow}, {16'h9999, 2'b01});
        cyc(1);
        checkVal("borrow_one_cycle", {Digits, Carry, Borrow}, {16'h9999, 2'b00});
        BtnDown = 1'b0;
        cyc(2);

        // Carry wrap from all 9s
        BtnUp = 1'b1;
        cyc(2);
        checkVal("carry_wrap", {Digits, Carry, Borrow}, {16'h0000, 2'b10});
        cyc(1);
        checkVal("carry_one_cycle", {Digits, Carry, Borrow}, {16'h0000, 2'b00});
        BtnUp = 1'b0;
        cyc(2);

        // Enter RUN and count to 42 with a held Tick (one count per cycle)
        press(START);
        checkVal("running_on", Running, 1'b1);
        Tick = 1'b1;
        cyc(42);
        Tick = 1'b0;
        checkVal("tick_held_42", Digits, 16'h0042);
        cyc(1);
        checkVal("tick_released", Digits, 16'h0042);

        // Clear beats Down, Up and Tick in the execute cycle
        BtnUp = 1'b1; BtnDown = 1'b1; BtnClear = 1'b1;
        cyc(1);
        Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        checkVal("clear_priority", {Digits, Carry, Borrow}, {16'h0000, 2'b00});
        BtnUp = 1'b0; BtnDown = 1'b0; BtnClear = 1'b0;
        cyc(2);
        checkVal("clear_no_queue", Digits, 16'h0000);

        // Down beats Up
        Tick = 1'b1;
        cyc(42);
        Tick = 1'b0;
        checkVal("reload_42", Digits, 16'h0042);
        BtnUp = 1'b1; BtnDown = 1'b1;
        cyc(2);
        checkVal("down_priority", Digits, 16'h0041);
        BtnUp = 1'b0; BtnDown = 1'b0;
        cyc(2);
        checkVal("down_no_queue", Digits, 16'h0041);

        // Tick gating in STOP and RUN
        press(START);
        checkVal("running_off", Running, 1'b0);
        tickPulses(5);
        checkVal("stop_ticks_ignored", Digits, 16'h0041);
        press(START);
        tickPulses(5);
        checkVal("run_ticks_count", {Digits, Running}, {16'h0046, 1'b1});

        // Start + Tick together: ignored from STOP, counted from RUN
        press(START);
        checkVal("stopped_again", {Digits, Running}, {16'h0046, 1'b0});
        BtnStart = 1'b1;
        cyc(1);
        Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        checkVal("start_tick_from_stop", {Digits, Running}, {16'h0046, 1'b1});
        BtnStart = 1'b0;
        cyc(2);
        BtnStart = 1'b1;
        cyc(1);
        Tick = 1'b1;
        cyc(1);
        Tick = 1'b0;
        checkVal("start_tick_from_run", {Digits, Running}, {16'h0047, 1'b0});
        BtnStart = 1'b0;
        cyc(2);

        // Reach 0123 in RUN, then reset asynchronously with BtnUp held
        press(START);
        Tick = 1'b1;
        cyc(76);
        Tick = 1'b0;
        checkVal("pre_reset_value", {Digits, Running}, {16'h0123, 1'b1});
        BtnUp = 1'b1;
        #1 Reset = 1'b0;
        #1 checkVal("async_reset", {Digits, Running, Carry, Borrow}, {16'h0000, 3'b000});
        #1 Reset = 1'b1;
        cyc(1);
        checkVal("post_reset_k", {Digits, Running}, {16'h0000, 1'b0});
        cyc(1);
        checkVal("post_reset_one_edge", Digits, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            checkVal("post_reset_held", Digits, 16'h0001);
        end
        BtnUp = 1'b0;
        cyc(3);
        checkVal("post_reset_final", {Digits, Running}, {16'h0001, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
